// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and constants for the FIFO read-side stream block
//
// Purpose : FSM state encoding and skid buffer depth used by fifo_rd_stream and fifo_rd_skid.
// Ports   : none (package).
package fifo_rd_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry in-order prefetch/skid buffer
//
// Purpose : holds words popped from the FIFO until the stream accepts them.
// Ports   : clk, rst_n      clock / async active-low reset
//           push, push_data append a word at the tail
//           pop             remove the head word
//           clear           drop all entries (wins over push/pop)
//           occ             number of valid entries (0..2)
//           head_data       oldest entry
import fifo_rd_pkg::*;

module fifo_rd_skid #(
  parameter int DATA_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  input  logic                 clear,
  output logic [OCC_W-1:0]     occ,
  output logic [DATA_SIZE-1:0] head_data
);

  logic [DATA_SIZE-1:0] ent0;
  logic [DATA_SIZE-1:0] ent1;

  assign head_data = ent0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (clear) begin
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == '0) ent0 <= push_data;
          else           ent1 <= push_data;
          occ <= occ + 1'b1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 1'b1;
        end
        2'b11: begin
          // Head leaves while a new word arrives: occupancy holds, order is kept.
          if (occ == OCC_W'(1)) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-port consumer presenting a valid/ready stream
//
// Purpose : pops the FIFO read port into a 2-entry skid buffer and streams words out at up to
//           one per cycle; a flush pulse discards buffered words and drains the FIFO.
// Config  : FIFO_RD_STAT_EN enables the words_rd / words_drop saturating counters.
// Ports   : rd_clk, rd_rst_n       read clock / async active-low reset
//           fifo_empty, fifo_rd_data, fifo_rd_en   FIFO read port (1-cycle read latency)
//           m_valid, m_data, m_ready               output stream
//           flush, busy            drain request / drain in progress
//           words_rd, words_drop   delivered / discarded word counts
import fifo_rd_pkg::*;

module fifo_rd_stream #(
  parameter int DATA_SIZE = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  output logic [DATA_SIZE-1:0] m_data,
  input  logic                 m_ready,
  input  logic                 flush,
  output logic                 busy,
  output logic [CNT_W-1:0]     words_rd,
  output logic [CNT_W-1:0]     words_drop
);

  state_t           state;
  state_t           state_nxt;
  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic             xfer;
  logic             enter_flush;
  logic [2:0]       committed;
  logic             room;

  assign m_valid     = (state != ST_FLUSH) && (occ != '0);
  assign xfer        = m_valid && m_ready;
  assign busy        = (state == ST_FLUSH);
  assign enter_flush = flush && (state != ST_FLUSH);

  // Slots already spoken for after this edge if we pop now: buffered + in flight + this pop,
  // less the word leaving on the stream. occ=0 implies xfer=0, so this never underflows.
  assign committed = 3'(occ) + {2'b00, inflight} + 3'd1 - {2'b00, xfer};
  assign room      = (committed <= 3'(SKID_DEPTH));

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      ST_IDLE: begin
        // Popping already in IDLE gives fifo_empty-fall to m_valid in two cycles.
        fifo_rd_en = !fifo_empty && room;
        if (!fifo_empty || occ != '0) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        fifo_rd_en = !fifo_empty && room;
        if (occ == '0 && !inflight && fifo_empty) state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_empty && !inflight) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (enter_flush) state_nxt = ST_FLUSH;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state    <= ST_IDLE;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
    end
  end

  // Words arriving while flushing (or on the flush-entry edge) are simply not pushed.
  fifo_rd_skid #(.DATA_SIZE(DATA_SIZE)) u_skid (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (inflight && (state != ST_FLUSH) && !enter_flush),
    .push_data (fifo_rd_data),
    .pop       (xfer),
    .clear     (enter_flush),
    .occ       (occ),
    .head_data (m_data)
  );

`ifdef FIFO_RD_STAT_EN
  logic [1:0] drop_now;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    drop_now = 2'd0;
    if (enter_flush)            drop_now = 2'(occ) - {1'b0, xfer} + {1'b0, inflight};
    else if (state == ST_FLUSH) drop_now = {1'b0, inflight};
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      words_rd   <= '0;
      words_drop <= '0;
    end else begin
      words_rd   <= sat_add(words_rd, {1'b0, xfer});
      words_drop <= sat_add(words_drop, drop_now);
    end
  end
`else
  assign words_rd   = '0;
  assign words_drop = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream with a FIFO model
module tb_fifo_rd_stream;

  localparam int DW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          flush;
  logic          busy;
  logic [CW-1:0] words_rd;
  logic [CW-1:0] words_drop;

  logic          wr_en;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
    .rd_clk       (clk),
    .rd_rst_n     (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .flush        (flush),
    .busy         (busy),
    .words_rd     (words_rd),
    .words_drop   (words_drop)
  );

  // FIFO model: write side driven by the bench, 1-cycle read latency, reset with the DUT.
  logic [DW-1:0] mem [64];
  int wp;
  int rp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp           <= 0;
      rp           <= 0;
      fifo_rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wp % 64] <= wr_data;
        wp           <= wp + 1;
      end
      if (fifo_rd_en) begin
        fifo_rd_data <= mem[rp % 64];
        rp           <= rp + 1;
      end
    end
  end

  assign fifo_empty = (wp == rp);

  // Stream monitor; counters only grow, the main sequence works with snapshots.
  int cyc = 0;
  logic [DW-1:0] got[$];
  int got_cyc[$];
  int pops = 0;
  int viol = 0;
  int vhi = 0;
  int busy_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
      end
      if (fifo_rd_en) pops++;
      if (fifo_rd_en && fifo_empty) viol++;
      if (m_valid) vhi++;
      if (busy) busy_n++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int got_at(input int i);
    return (i < got.size()) ? int'(got[i]) : -1;
  endfunction

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = DW'(first + i);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int b;
  int p0;
  int v0;
  int bz0;
  int bad;

  initial begin
    wr_en   = 1'b0;
    wr_data = '0;
    m_ready = 1'b0;
    flush   = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_words_rd", words_rd, 0);
    check("rst_words_drop", words_drop, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty FIFO in IDLE: nothing happens for 20 cycles.
    m_ready = 1'b1;
    p0 = pops;
    v0 = vhi;
    cycles(20);
    check("idle_rd_en", pops - p0, 0);
    check("idle_m_valid", vhi - v0, 0);

    // 1..15 with m_ready held: 2-cycle fill, then one word per cycle.
    b = got.size();
    fork
      push_words(1, 15);
      begin
        @(posedge clk);
        @(negedge clk); check("lat_rd_en_before", fifo_rd_en, 0);
        @(negedge clk); check("lat_rd_en_t", fifo_rd_en, 1);
                        check("lat_valid_t", m_valid, 0);
        @(negedge clk); check("lat_valid_t1", m_valid, 0);
        @(negedge clk); check("lat_valid_t2", m_valid, 1);
                        check("lat_data_t2", m_data, 1);
      end
    join
    cycles(5);
    check("run_count", got.size() - b, 15);
    for (int i = 0; i < 15; i++) check($sformatf("run_word%0d", i), got_at(b + i), i + 1);
    if (got.size() >= b + 15) check("run_back_to_back", got_cyc[b + 14] - got_cyc[b], 14);
    else                      check("run_back_to_back", 0, 14);

    // Backpressure: head word held, exactly two pops, then in-order release.
    m_ready = 1'b0;
    b  = got.size();
    p0 = pops;
    push_words(1, 4);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== DW'(1)) bad++;
    end
    check("bp_hold_stable", bad, 0);
    check("bp_pops", pops - p0, 2);
    check("bp_no_xfer", got.size() - b, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    cycles(8);
    check("bp_count", got.size() - b, 4);
    for (int i = 0; i < 4; i++) check($sformatf("bp_word%0d", i), got_at(b + i), i + 1);

    // Toggling m_ready against a continuous supply of 0..15.
    b  = got.size();
    v0 = viol;
    fork
      push_words(0, 16);
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          m_ready = ~m_ready;
        end
      end
    join
    m_ready = 1'b1;
    cycles(5);
    check("tog_count", got.size() - b, 16);
    for (int i = 0; i < 16; i++) check($sformatf("tog_word%0d", i), got_at(b + i), i);
    check("tog_pop_when_empty", viol - v0, 0);

    // Flush: 5 words written, 1 delivered, 2 buffered + 2 drained from FIFO are dropped.
    do_reset();
    b = got.size();
    m_ready = 1'b0;
    push_words(1, 5);
    cycles(4);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    cycles(2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    v0  = vhi;
    bz0 = busy_n;
    check("fl_busy_entry", busy, 1);
    cycles(10);
    check("fl_busy_cycles", busy_n - bz0, 4);
    check("fl_busy_end", busy, 0);
    check("fl_fifo_drained", fifo_empty, 1);
    check("fl_no_valid", vhi - v0, 0);
    check("fl_delivered", got.size() - b, 1);
    check("fl_word0", got_at(b), 1);
`ifdef FIFO_RD_STAT_EN
    check("fl_words_drop", words_drop, 4);
    check("fl_words_rd", words_rd, 1);
`else
    check("fl_words_drop", words_drop, 0);
    check("fl_words_rd", words_rd, 0);
`endif

    // Asynchronous reset mid-stream, then fresh words 7,8.
    m_ready = 1'b1;
    fork
      push_words(1, 10);
      begin
        cycles(6);
        #1;
        check("mid_pre_rd_en", fifo_rd_en, 1);
        check("mid_pre_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", fifo_rd_en, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
      end
    join
    @(posedge clk); #1;
    rst_n = 1'b1;
    b = got.size();
    push_words(7, 2);
    cycles(6);
    check("post_rst_count", got.size() - b, 2);
    check("post_rst_word0", got_at(b), 7);
    check("post_rst_word1", got_at(b + 1), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
